// File: rtl/mips_bus_pkg.sv
// Shared types for the MIPS bus memory: handshake state encoding and data word width.
package mips_bus_pkg;
  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;
endpackage

// File: rtl/mips_bus_if.sv
// Avalon-style master/slave bus: held request, waitrequest stall, read data in the accept cycle.
interface mips_bus_if;
  import mips_bus_pkg::*;

  logic [31:0] address;
  logic        read;
  logic        write;
  word_t       writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  word_t       readdata;
  logic        fault;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata, fault
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata, fault
  );
endinterface

// File: rtl/mips_bus_ram_array.sv
// Word storage: one synchronous read port, one byte-enabled synchronous write port.
// Latency: read data appears the cycle after rd_en; writes commit on the clock edge with wr_en.
// Backpressure: none, every port access is accepted each cycle and contents survive reset.
module mips_bus_ram_array
  import mips_bus_pkg::*;
#(
  parameter int    DEPTH_LOG2 = 10,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  rd_en,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output word_t                 rd_data,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  word_t                 wr_data,
  input  logic [3:0]            wr_be
);
  word_t mem [0:(1<<DEPTH_LOG2)-1];

  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end
endmodule

// File: rtl/mips_bus_memory.sv
// Bus-attached memory: WAIT_CYCLES+1 stall cycles, then one accept cycle; writes commit at the end of it.
// Backpressure via waitrequest while a held request is pending; protocol/address errors latch a sticky fault.
module mips_bus_memory
  import mips_bus_pkg::*;
#(
  parameter int          WAIT_CYCLES = 2,
  parameter int          DEPTH_LOG2  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
  parameter string       INIT_FILE   = ""
) (
  input  logic      clk,
  input  logic      reset,
  mips_bus_if.slave bus
);
  localparam int            CW        = $clog2(WAIT_CYCLES + 2);
  localparam logic [CW-1:0] WAIT_LOAD = CW'(WAIT_CYCLES);

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_next;
  logic                  rd_vld;
  logic                  fault_q;
  logic                  req;
  logic                  go_ack;
  logic                  in_range;
  logic                  bad_req;
  logic                  rd_en;
  logic                  wr_en;
  logic [29:0]           word_off;
  logic [DEPTH_LOG2-1:0] word_idx;
  word_t                 rd_data;

  assign req      = bus.read | bus.write;
  assign word_off = bus.address[31:2] - BASE_ADDR[31:2];
  assign in_range = (word_off[29:DEPTH_LOG2] == '0);
  assign word_idx = word_off[DEPTH_LOG2-1:0];
  assign bad_req  = !in_range || (bus.address[1:0] != 2'b00) || (bus.read && bus.write);

  // The counter value after this edge decides ACK, so WAIT_CYCLES=0 goes straight from IDLE to ACK.
  assign cnt_next = (state == IDLE) ? WAIT_LOAD : cnt - CW'(1);
  assign go_ack   = req && (state != ACK) && (cnt_next == '0);

  assign rd_en = go_ack && bus.read && in_range && !reset;
  assign wr_en = (state == ACK) && bus.write && !bus.read && in_range && !reset;

  assign bus.waitrequest = req && (state != ACK);
  assign bus.readdata    = (state == ACK && rd_vld) ? rd_data : '0;
  assign bus.fault       = fault_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      rd_vld  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            cnt    <= cnt_next;
            rd_vld <= bus.read && in_range;
            state  <= go_ack ? ACK : WAIT;
            if (bad_req) fault_q <= 1'b1;
          end
        end
        WAIT: begin
          if (!req) begin
            state   <= IDLE;
            cnt     <= '0;
            rd_vld  <= 1'b0;
            fault_q <= 1'b1;
          end else begin
            cnt    <= cnt_next;
            rd_vld <= bus.read && in_range;
            if (go_ack) state <= ACK;
          end
        end
        ACK: begin
          state  <= IDLE;
          cnt    <= '0;
          rd_vld <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  mips_bus_ram_array #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .INIT_FILE  (INIT_FILE)
  ) u_ram (
    .clk     (clk),
    .rd_en   (rd_en),
    .rd_addr (word_idx),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_addr (word_idx),
    .wr_data (bus.writedata),
    .wr_be   (bus.byteenable)
  );
endmodule

// File: tb/tb_mips_bus_memory.sv
// Randomized transfers against a transaction-level memory model, plus directed corner cases.
module tb_mips_bus_memory;
  localparam int          W    = 2;
  localparam logic [31:0] BASE = 32'hBFC00000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mips_bus_if b();
  mips_bus_if b0();

  mips_bus_memory #(.WAIT_CYCLES(W), .DEPTH_LOG2(10), .BASE_ADDR(BASE), .INIT_FILE("")) dut (
    .clk(clk), .reset(reset), .bus(b)
  );
  mips_bus_memory #(.WAIT_CYCLES(0), .DEPTH_LOG2(10), .BASE_ADDR(BASE), .INIT_FILE("")) dut0 (
    .clk(clk), .reset(reset), .bus(b0)
  );

  logic [31:0] mem_m [0:15];
  logic        fault_m;
  logic        chk_en;
  logic        exp_wait;
  logic [31:0] exp_rdata;
  logic        exp_fault;
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          ack_cyc = 0;
  int          prev_ack_cyc = 0;
  int          stall_run = 0;
  int          last_stall = 0;
  logic [31:0] last_ack_rd = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (chk_en) begin
      check("waitrequest", {31'd0, b.waitrequest}, {31'd0, exp_wait});
      check("readdata", b.readdata, exp_rdata);
      check("fault", {31'd0, b.fault}, {31'd0, exp_fault});
    end
    if (b.waitrequest) stall_run++;
    else if (b.read || b.write) begin
      prev_ack_cyc = ack_cyc;
      ack_cyc      = cyc;
      last_ack_rd  = b.readdata;
      last_stall   = stall_run;
      stall_run    = 0;
    end else stall_run = 0;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    b.read = 1'b0; b.write = 1'b0;
    exp_wait = 1'b0; exp_rdata = '0; exp_fault = fault_m;
    repeat (n) step();
  endtask

  // Model: W+1 stall cycles, one accept cycle, write lands after the accept cycle.
  task automatic xfer(input logic [31:0] addr, input logic rd, input logic wr,
                      input logic [31:0] wd, input logic [3:0] be, input int wd_at, input bit hold);
    logic [31:0] idx;
    logic        inr;
    logic        new_f;
    idx   = (addr - BASE) >> 2;
    inr   = idx < 32'd1024;
    new_f = fault_m | !inr | (addr[1:0] != 2'b00) | (rd & wr);
    b.address = addr; b.read = rd; b.write = wr; b.writedata = wd; b.byteenable = be;
    exp_wait = 1'b1; exp_rdata = '0; exp_fault = fault_m;
    step();
    for (int k = 1; k <= W; k++) begin
      if (k == wd_at) begin
        b.read = 1'b0; b.write = 1'b0;
        exp_wait = 1'b0; exp_fault = new_f;
        step();
        fault_m = 1'b1; exp_fault = 1'b1;
        return;
      end
      exp_fault = new_f;
      step();
    end
    fault_m   = new_f;
    exp_wait  = 1'b0;
    exp_rdata = (rd && inr) ? mem_m[idx[3:0]] : 32'd0;
    exp_fault = new_f;
    step();
    if (wr && !rd && inr)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem_m[idx[3:0]][8*i +: 8] = wd[8*i +: 8];
    exp_rdata = '0;
    if (!hold) begin
      b.read = 1'b0; b.write = 1'b0; exp_wait = 1'b0;
    end
  endtask

  task automatic do_reset();
    chk_en = 1'b0; reset = 1'b1;
    b.read = 1'b0; b.write = 1'b0;
    step(); step();
    reset = 1'b0; fault_m = 1'b0;
    exp_wait = 1'b0; exp_rdata = '0; exp_fault = 1'b0;
    chk_en = 1'b1;
  endtask

  initial begin
    logic [31:0] a, v, wd0;
    logic        rd, wr;
    int          r, k, idx;
    chk_en = 1'b0; reset = 1'b1; fault_m = 1'b0;
    exp_wait = 1'b0; exp_rdata = '0; exp_fault = 1'b0;
    b.address = '0; b.read = 1'b0; b.write = 1'b0; b.writedata = '0; b.byteenable = '0;
    b0.address = '0; b0.read = 1'b0; b0.write = 1'b0; b0.writedata = '0; b0.byteenable = '0;
    repeat (2) step();
    chk_en = 1'b1;
    step();
    check("rst_fault", {31'd0, b.fault}, 32'd0);
    check("rst_readdata", b.readdata, 32'd0);
    check("rst_waitrequest", {31'd0, b.waitrequest}, 32'd0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 16; i++) xfer(BASE + 32'(i * 4), 1'b0, 1'b1, $urandom, 4'hF, 0, 1'b0);

    xfer(BASE, 1'b0, 1'b1, 32'h24020005, 4'hF, 0, 1'b0);
    xfer(BASE, 1'b1, 1'b0, 32'h0, 4'hF, 0, 1'b0);
    check("req036_rdata", last_ack_rd, 32'h24020005);
    check("req036_stall", 32'(last_stall), 32'd3);

    xfer(BASE + 8, 1'b0, 1'b1, 32'h0, 4'hF, 0, 1'b0);
    xfer(BASE + 8, 1'b0, 1'b1, 32'hDEADBEEF, 4'b0101, 0, 1'b0);
    xfer(BASE + 8, 1'b1, 1'b0, 32'h0, 4'hF, 0, 1'b0);
    check("req037_rdata", last_ack_rd, 32'h00AD00EF);
    check("req037_model", mem_m[2], 32'h00AD00EF);

    xfer(BASE + 4, 1'b1, 1'b0, 32'h0, 4'hF, 0, 1'b1);
    check("req038_rdata0", last_ack_rd, mem_m[1]);
    xfer(BASE + 8, 1'b1, 1'b0, 32'h0, 4'hF, 0, 1'b0);
    check("req038_rdata1", last_ack_rd, 32'h00AD00EF);
    check("req038_spacing", 32'(ack_cyc - prev_ack_cyc), 32'd4);
    check("req038_fault", {31'd0, b.fault}, 32'd0);
    idle(1);

    for (int n = 0; n < 200; n++) begin
      r   = $urandom_range(0, 15);
      idx = $urandom_range(0, 15);
      a   = BASE + 32'(idx * 4);
      if (r == 0) a = a + 32'($urandom_range(1, 3));
      if (r == 1) a = BASE + 32'((1024 + $urandom_range(0, 100)) * 4);
      if (r == 2) a = BASE - 32'd4;
      k  = $urandom_range(0, 9);
      rd = (k <= 4) || (k == 9);
      wr = (k >= 5);
      xfer(a, rd, wr, $urandom, 4'($urandom_range(0, 15)),
           ($urandom_range(0, 11) == 0) ? $urandom_range(1, W) : 0, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    idle(1);

    do_reset();
    xfer(BASE + (32'd4 << 10), 1'b1, 1'b0, 32'h0, 4'hF, 0, 1'b0);
    check("req039_rdata", last_ack_rd, 32'd0);
    idle(3);
    check("req039_fault", {31'd0, b.fault}, 32'd1);

    v = mem_m[5];
    b.address = BASE + 20; b.write = 1'b1; b.read = 1'b0; b.writedata = ~v; b.byteenable = 4'hF;
    exp_wait = 1'b1; exp_rdata = '0; exp_fault = fault_m;
    step();
    reset = 1'b1; b.write = 1'b0; exp_wait = 1'b0;
    step();
    reset = 1'b0; fault_m = 1'b0; exp_fault = 1'b0;
    idle(2);
    check("req040_fault", {31'd0, b.fault}, 32'd0);
    check("req040_readdata", b.readdata, 32'd0);
    xfer(BASE + 20, 1'b1, 1'b0, 32'h0, 4'hF, 0, 1'b0);
    check("req040_word", last_ack_rd, v);
    idle(1);

    wd0 = 32'h12345678;
    b0.address = BASE + 4; b0.write = 1'b1; b0.writedata = wd0; b0.byteenable = 4'hF;
    @(negedge clk) check("w0_init_stall", {31'd0, b0.waitrequest}, 32'd1);
    step();
    @(negedge clk) check("w0_init_ack", {31'd0, b0.waitrequest}, 32'd0);
    step();
    b0.write = 1'b0;
    b0.read = 1'b1; b0.write = 1'b1; b0.writedata = 32'h0; b0.byteenable = 4'hF;
    @(negedge clk) begin
      check("req041_stall", {31'd0, b0.waitrequest}, 32'd1);
      check("req041_fault0", {31'd0, b0.fault}, 32'd0);
    end
    step();
    @(negedge clk) begin
      check("req041_ack", {31'd0, b0.waitrequest}, 32'd0);
      check("req041_rdata", b0.readdata, wd0);
      check("req041_fault1", {31'd0, b0.fault}, 32'd1);
    end
    step();
    b0.read = 1'b0; b0.write = 1'b0;
    step();
    b0.read = 1'b1;
    step();
    @(negedge clk) check("req041_mem", b0.readdata, wd0);
    step();
    b0.read = 1'b0;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mips_bus_memory.md
MIPS_BUS_MEMORY -- requirements
Module: mips_bus_memory

Interface
REQ-001 Parameter WAIT_CYCLES, default 2: extra stall cycles per transfer beyond the mandatory first one.
REQ-002 Parameter DEPTH_LOG2, default 10: memory holds 2^DEPTH_LOG2 32-bit words.
REQ-003 Parameter BASE_ADDR, default 32'hBFC00000: byte address of word 0.
REQ-004 Parameter INIT_FILE, default "" (none): hex image loaded into memory at elaboration when non-empty.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 address  input  32  byte address from the bus master.
REQ-008 read  input  1  read request, held by master until accepted.
REQ-009 write  input  1  write request, held by master until accepted.
REQ-010 writedata  input  32  write data.
REQ-011 byteenable  input  4  lane i enables bits [8i+7:8i].
REQ-012 waitrequest  output  1  high = transfer not yet accepted.
REQ-013 readdata  output  32  read data, valid in the accept cycle.
REQ-014 fault  output  1  sticky protocol/address error flag.

Function
REQ-015 FSM states SHALL be IDLE, WAIT, ACK.
REQ-016 IDLE: on read or write, go to WAIT with the stall counter loaded to WAIT_CYCLES; otherwise stay in IDLE.
REQ-017 WAIT: decrement the counter each cycle; move to ACK on the edge where the counter is 0.
REQ-018 waitrequest SHALL be combinational: 1 when (read|write) and state!=ACK, else 0.
REQ-019 Transfer latency SHALL be WAIT_CYCLES+1 cycles of waitrequest high, then exactly one ACK cycle with waitrequest low.
REQ-020 readdata SHALL be registered on entry to ACK and hold the addressed word through the ACK cycle; otherwise readdata is 0.
REQ-021 A write SHALL update the memory on the clock edge ending the ACK cycle, byte lanes gated by byteenable; byteenable 4'b0000 completes with no change.
REQ-022 Reads SHALL return the full word regardless of byteenable.
REQ-023 ACK SHALL always return to IDLE; a request held in the following cycle starts a new transfer (no bypass).
REQ-024 Word index = (address - BASE_ADDR) >> 2, modulo 32-bit wrap.
REQ-025 Index >= 2^DEPTH_LOG2: read returns 0, write is ignored, fault is set; handshake timing is unchanged.
REQ-026 address[1:0] != 0: the low bits are ignored for indexing and fault is set.
REQ-027 read and write both high: treat as a read with no memory update, and set fault.
REQ-028 Request withdrawn while in WAIT: return to IDLE, no memory update, set fault.
REQ-029 fault SHALL remain set until reset.

Reset
REQ-030 reset SHALL force state IDLE, counter 0, readdata 0 and fault 0.
REQ-031 Memory contents SHALL NOT be cleared by reset.
REQ-032 Reset during WAIT or ACK SHALL abort the transfer with no memory update.

Structure
REQ-033 State enum and the 32-bit word-width constant SHALL live in shared package mips_bus_pkg.
REQ-034 Storage SHALL be a sub-module mips_bus_ram_array: one synchronous read port, one byte-enabled synchronous write port, INIT_FILE load.
REQ-035 Handshake FSM, address decode and fault logic SHALL stay in mips_bus_memory.

Verification
REQ-036 WAIT_CYCLES=2, read of BASE_ADDR with INIT word0=32'h24020005 -> waitrequest high for 3 cycles, then 1 cycle low with readdata=32'h24020005.
REQ-037 Write 32'hDEADBEEF with byteenable 4'b0101 to BASE_ADDR+8 (old value 0), then read back -> 32'h00AD00EF.
REQ-038 Back-to-back reads of BASE_ADDR+4 and BASE_ADDR+8, with read held continuously -> two ACK cycles 4 cycles apart, correct data each time, fault=0.
REQ-039 Read of BASE_ADDR+(4<<DEPTH_LOG2) -> normal handshake, readdata=0, fault=1 until reset.
REQ-040 Write started, reset asserted during WAIT -> state IDLE, target word unchanged, fault=0, readdata=0.
REQ-041 WAIT_CYCLES=0 with read and write both high -> 1 stall cycle then ACK, read data returned, memory unchanged, fault=1.
